// File: rtl/cfg_frame_pkg.sv
// Shared constants and FSM state type for the config-frame receive path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cfg_frame_pkg;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
    localparam logic [7:0] CMD_WRITE     = 8'h01;
    localparam logic [7:0] CMD_END       = 8'h02;
    localparam logic [7:0] CHK_SEED      = 8'h5A;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DATA,
        ST_CHK,
        ST_EMIT
    } rx_state_t;

endpackage

// File: rtl/cfg_timeout.sv
// Inter-byte watchdog: flags when run stays high for TIMEOUT cycles without a clr.
// Latency: expired is combinational from the counter; counter restarts the cycle after clr/expiry.
// Backpressure: none; clr wins over counting, counting only while run is high.
module cfg_timeout #(
    parameter int TO_W    = 16,
    parameter int TIMEOUT = 40000
) (
    input  logic clk_dot4x,
    input  logic rst,
    input  logic clr,
    input  logic run,
    output logic expired
);

    localparam logic [TO_W-1:0] LAST = TO_W'(TIMEOUT - 1);

    logic [TO_W-1:0] cnt;

    assign expired = run && !clr && (cnt == LAST);

    // count idle cycles while armed; any byte, disarm or expiry restarts from zero
    always_ff @(posedge clk_dot4x or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr || !run || expired) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/cfg_frame_rx.sv
// Decodes SYNC/CMD/ADDR/DATA[/CHK] config frames from the dot4x byte stream into register writes.
// Latency: reg_valid, load_done and frame_err appear one cycle after the last byte strobe.
// Backpressure: none upstream; a byte arriving while a write waits unaccepted is dropped and flagged as overrun.
// Build option CFG_CHECKSUM_EN: adds the trailing CHK byte (CMD^ADDR^DATA^0x5A).
module cfg_frame_rx
    import cfg_frame_pkg::*;
#(
    parameter int         TO_W      = 16,
    parameter int         TIMEOUT   = 40000,
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF
) (
    input  logic       clk_dot4x,
    input  logic       rst,
    input  logic [7:0] rx_data_4x,
    input  logic       rx_new_data_4x,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_data,
    output logic       reg_valid,
    input  logic       reg_ready,
    output logic       load_done,
    output logic       frame_err,
    output logic       overrun,
    output logic [7:0] err_count
);

    rx_state_t  state, state_nxt;
    logic [7:0] cmd_q, addr_q;
    logic [7:0] frame_data;
    logic       chk_ok, frame_end, frame_good, wr_ok;
    logic       is_sync, to_run, to_expired;
    logic       reg_valid_nxt, load_nxt, ferr_nxt, ovr_nxt;
    logic [7:0] reg_addr_nxt, reg_data_nxt;

    assign is_sync = (rx_data_4x == SYNC_BYTE);
    assign to_run  = state inside {ST_CMD, ST_ADDR, ST_DATA, ST_CHK};

`ifdef CFG_CHECKSUM_EN
    logic [7:0] data_q, chk_acc;

    assign frame_end  = rx_new_data_4x && (state == ST_CHK);
    assign frame_data = data_q;
    assign chk_ok     = (chk_acc == rx_data_4x);

    // hold DATA and fold CMD/ADDR/DATA into the checksum; any other byte re-seeds it for the next frame
    always_ff @(posedge clk_dot4x or posedge rst) begin
        if (rst) begin
            data_q  <= '0;
            chk_acc <= '0;
        end else if (rx_new_data_4x) begin
            if (state == ST_DATA) begin
                data_q <= rx_data_4x;
            end
            if (state inside {ST_CMD, ST_ADDR, ST_DATA}) begin
                chk_acc <= chk_acc ^ rx_data_4x;
            end else begin
                chk_acc <= CHK_SEED;
            end
        end
    end
`else
    assign frame_end  = rx_new_data_4x && (state == ST_DATA);
    assign frame_data = rx_data_4x;
    assign chk_ok     = 1'b1;
`endif

    assign frame_good = chk_ok && ((cmd_q == CMD_WRITE) || (cmd_q == CMD_END));
    assign wr_ok      = frame_good && (cmd_q == CMD_WRITE);

    cfg_timeout #(
        .TO_W    (TO_W),
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk_dot4x (clk_dot4x),
        .rst       (rst),
        .clr       (rx_new_data_4x),
        .run       (to_run),
        .expired   (to_expired)
    );

    // FSM state register
    always_ff @(posedge clk_dot4x or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state: one step per byte strobe, timeout aborts any partial frame
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (rx_new_data_4x && is_sync) state_nxt = ST_CMD;
            end
            ST_CMD: begin
                if (rx_new_data_4x)  state_nxt = ST_ADDR;
                else if (to_expired) state_nxt = ST_IDLE;
            end
            ST_ADDR: begin
                if (rx_new_data_4x)  state_nxt = ST_DATA;
                else if (to_expired) state_nxt = ST_IDLE;
            end
            ST_DATA: begin
                if (rx_new_data_4x) begin
`ifdef CFG_CHECKSUM_EN
                    state_nxt = ST_CHK;
`else
                    state_nxt = wr_ok ? ST_EMIT : ST_IDLE;
`endif
                end else if (to_expired) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_CHK: begin
                if (rx_new_data_4x)  state_nxt = wr_ok ? ST_EMIT : ST_IDLE;
                else if (to_expired) state_nxt = ST_IDLE;
            end
            ST_EMIT: begin
                // accepted write frees the receiver in time to catch a SYNC in the same cycle
                if (reg_ready) state_nxt = (rx_new_data_4x && is_sync) ? ST_CMD : ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // FSM outputs: decide next-cycle write/pulse values from frame end, handshake and timeout
    always_comb begin
        reg_valid_nxt = reg_valid;
        reg_addr_nxt  = reg_addr;
        reg_data_nxt  = reg_data;
        load_nxt      = 1'b0;
        ferr_nxt      = 1'b0;
        ovr_nxt       = 1'b0;
        if (state == ST_EMIT) begin
            if (reg_ready)           reg_valid_nxt = 1'b0;
            else if (rx_new_data_4x) ovr_nxt       = 1'b1;
        end
        if (frame_end) begin
            if (wr_ok) begin
                reg_valid_nxt = 1'b1;
                reg_addr_nxt  = addr_q;
                reg_data_nxt  = frame_data;
            end else if (frame_good) begin
                load_nxt = 1'b1;
            end else begin
                ferr_nxt = 1'b1;
            end
        end
        if (to_expired) ferr_nxt = 1'b1;
    end

    // register the write and the single-cycle status pulses
    always_ff @(posedge clk_dot4x or posedge rst) begin
        if (rst) begin
            reg_valid <= 1'b0;
            reg_addr  <= '0;
            reg_data  <= '0;
            load_done <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            reg_valid <= reg_valid_nxt;
            reg_addr  <= reg_addr_nxt;
            reg_data  <= reg_data_nxt;
            load_done <= load_nxt;
            frame_err <= ferr_nxt;
            overrun   <= ovr_nxt;
        end
    end

    // capture CMD and ADDR bytes as they stream past
    always_ff @(posedge clk_dot4x or posedge rst) begin
        if (rst) begin
            cmd_q  <= '0;
            addr_q <= '0;
        end else if (rx_new_data_4x) begin
            if (state == ST_CMD)  cmd_q  <= rx_data_4x;
            if (state == ST_ADDR) addr_q <= rx_data_4x;
        end
    end

    // saturating error tally; coincident frame_err and overrun count once
    always_ff @(posedge clk_dot4x or posedge rst) begin
        if (rst) begin
            err_count <= '0;
        end else if ((ferr_nxt || ovr_nxt) && (err_count != 8'hFF)) begin
            err_count <= err_count + 8'd1;
        end
    end

endmodule
